// File: rtl/tilemap_sequencer.sv
// -----------------------------------------------------------------------------
// tilemap_sequencer
//
// Upstream feeder for the tile drawer. On start it walks a MAP_COLS x MAP_ROWS
// tile map held in a synchronous map RAM, in row-major order. For each cell it
// reads the tile index, turns it into a ROM byte address (index * TILE_BYTES),
// and hands the tile to the drawer with a draw request. It then waits for
// drawer_active to rise (acceptance) and fall (tile finished) before moving on.
//
// Build option:
//   SKIP_EMPTY_EN  when defined, a cell holding tile index 0 is treated as
//                  empty. Its position/address outputs are still updated, but
//                  no draw is issued. When undefined, index 0 is drawn like any
//                  other tile.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          asynchronous, active-high reset
//   start          1-cycle pulse that begins a full map pass (ignored while busy)
//   map_rd_addr    map RAM read address, row*MAP_COLS+col (registered)
//   map_rd_data    map RAM read data, valid one cycle after map_rd_addr changes
//   tile_address   ROM base address of the current tile
//   x_pos, y_pos   pixel origin of the current tile (col*8, row*8)
//   draw           request to the drawer, held until drawer_active is seen high
//   drawer_active  drawer busy flag
//   busy           high from an accepted start until the pass completes
//   done           1-cycle pulse after the last tile completes
// -----------------------------------------------------------------------------
module tilemap_sequencer #(
   parameter int MAP_COLS   = 20,
   parameter int MAP_ROWS   = 15,
   parameter int IDX_W      = 5,
   parameter int TILE_BYTES = 192
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [8:0]       map_rd_addr,
   input  logic [IDX_W-1:0] map_rd_data,
   output logic [11:0]      tile_address,
   output logic [7:0]       x_pos,
   output logic [7:0]       y_pos,
   output logic             draw,
   input  logic             drawer_active,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_WAIT,
      LATCH,
      ISSUE,
      WAIT_DONE,
      ADVANCE,
      FINISH
   } state_t;

   localparam logic [8:0]  COLS_9   = 9'(MAP_COLS);
   localparam logic [4:0]  LAST_COL = 5'(MAP_COLS - 1);
   localparam logic [4:0]  LAST_ROW = 5'(MAP_ROWS - 1);
   localparam logic [11:0] TBYTES12 = 12'(TILE_BYTES);

   state_t     state;
   logic [4:0] col;
   logic [4:0] row;

   // Row-major cell address into the map RAM.
   function automatic logic [8:0] cell_addr(input logic [4:0] r, input logic [4:0] c);
      return 9'(r) * COLS_9 + 9'(c);
   endfunction

   // ROM base address; products beyond 12 bits wrap silently.
   function automatic logic [11:0] rom_addr(input logic [IDX_W-1:0] idx);
      return 12'(idx) * TBYTES12;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         col          <= '0;
         row          <= '0;
         map_rd_addr  <= '0;
         tile_address <= '0;
         x_pos        <= '0;
         y_pos        <= '0;
         draw         <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy  <= 1'b1;
                  col   <= '0;
                  row   <= '0;
                  state <= RD_ADDR;
               end
            end
            RD_ADDR: begin
               map_rd_addr <= cell_addr(row, col);
               state       <= RD_WAIT;
            end
            // Map RAM registers the new address during this cycle.
            RD_WAIT: begin
               state <= LATCH;
            end
            LATCH: begin
               tile_address <= rom_addr(map_rd_data);
               x_pos        <= {col, 3'b000};
               y_pos        <= {row, 3'b000};
`ifdef SKIP_EMPTY_EN
               if (map_rd_data == '0) begin
                  state <= ADVANCE;
               end else begin
                  draw  <= 1'b1;
                  state <= ISSUE;
               end
`else
               draw  <= 1'b1;
               state <= ISSUE;
`endif
            end
            // Drawer is known idle here, so active high means it took the tile.
            ISSUE: begin
               if (drawer_active) begin
                  draw  <= 1'b0;
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!drawer_active) begin
                  state <= ADVANCE;
               end
            end
            ADVANCE: begin
               if (col == LAST_COL && row == LAST_ROW) begin
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  if (col == LAST_COL) begin
                     col <= '0;
                     row <= row + 5'd1;
                  end else begin
                     col <= col + 5'd1;
                  end
                  state <= RD_ADDR;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tilemap_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for tilemap_sequencer on a 2x2 map. A stimulus thread pushes the
// expected (tile_address, x, y) of every draw into a scoreboard queue; a
// monitor pops and compares on each rising edge of draw. A behavioural drawer
// raises drawer_active acc_delay cycles after seeing draw and holds it for
// hold_cycles cycles.
// -----------------------------------------------------------------------------
module tb_tilemap_sequencer;

   typedef struct {
      logic [11:0] a;
      logic [7:0]  x;
      logic [7:0]  y;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [8:0]  map_rd_addr;
   logic [4:0]  map_rd_data;
   logic [11:0] tile_address;
   logic [7:0]  x_pos;
   logic [7:0]  y_pos;
   logic        draw;
   logic        drawer_active;
   logic        busy;
   logic        done;

   logic [4:0]  mem [0:3];
   exp_t        sb[$];
   int          n_chk;
   int          n_fail;
   int          n_draws;
   int          done_cnt;
   int          acc_delay;
   int          hold_cycles;
   logic        draw_q;

   tilemap_sequencer #(
      .MAP_COLS  (2),
      .MAP_ROWS  (2),
      .IDX_W     (5),
      .TILE_BYTES(192)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .map_rd_addr  (map_rd_addr),
      .map_rd_data  (map_rd_data),
      .tile_address (tile_address),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .draw         (draw),
      .drawer_active(drawer_active),
      .busy         (busy),
      .done         (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous map RAM, one cycle read latency.
   always_ff @(posedge clk) begin
      map_rd_data <= mem[map_rd_addr[1:0]];
   end

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int a, input int x, input int y);
      exp_t e;
      e.a = 12'(a);
      e.x = 8'(x);
      e.y = 8'(y);
      sb.push_back(e);
   endtask

   task automatic push_1234();
      push(192, 0, 0);
      push(384, 8, 0);
      push(576, 0, 8);
      push(768, 8, 8);
   endtask

   // Behavioural drawer.
   initial begin
      drawer_active = 1'b0;
      forever begin
         @(negedge clk);
         if (draw && !drawer_active) begin
            repeat (acc_delay) @(negedge clk);
            drawer_active = 1'b1;
            repeat (hold_cycles) @(negedge clk);
            drawer_active = 1'b0;
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      draw_q = 1'b0;
      forever begin
         @(negedge clk);
         if (draw && !draw_q) begin
            n_draws++;
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_draw: got addr %0d x %0d y %0d, expected no draw",
                        tile_address, x_pos, y_pos);
            end else begin
               e = sb.pop_front();
               check("tile_address", int'(tile_address), int'(e.a));
               check("x_pos", int'(x_pos), int'(e.x));
               check("y_pos", int'(y_pos), int'(e.y));
            end
         end
         if (done) done_cnt++;
         draw_q = draw;
      end
   end

   // Full pass: start, optional extra start at cycle mid_start, wait for done.
   task automatic run_pass(input int mid_start, input int exp_draws, input string tag);
      int d0;
      int n0;
      int cyc;
      @(negedge clk);
      d0    = done_cnt;
      n0    = n_draws;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, "_busy_after_start"}, int'(busy), 1);
      cyc = 0;
      while (done_cnt == d0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = (mid_start != 0 && cyc == mid_start);
      end
      start = 1'b0;
      check({tag, "_done_seen"}, done_cnt - d0, 1);
      repeat (6) @(negedge clk);
      check({tag, "_done_count"}, done_cnt - d0, 1);
      check({tag, "_busy_after_done"}, int'(busy), 0);
      check({tag, "_draw_count"}, n_draws - n0, exp_draws);
      check({tag, "_sb_empty"}, sb.size(), 0);
   endtask

   initial begin
      int cyc;
      int bad;
      logic [8:0] addr0;
      n_chk       = 0;
      n_fail      = 0;
      n_draws     = 0;
      done_cnt    = 0;
      acc_delay   = 2;
      hold_cycles = 10;
      mem[0] = 5'd1; mem[1] = 5'd2; mem[2] = 5'd3; mem[3] = 5'd4;
      reset = 1'b1;
      start = 1'b0;

      // 1: reset held with start pulses, then released
      repeat (3) @(negedge clk);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_draw", int'(draw), 0);
      check("rst_tile_address", int'(tile_address), 0);
      check("rst_x", int'(x_pos), 0);
      check("rst_y", int'(y_pos), 0);
      check("rst_map_rd_addr", int'(map_rd_addr), 0);
      repeat (5) @(negedge clk);
      check("rst_busy_later", int'(busy), 0);
      check("rst_no_draw", n_draws, 0);

      // 2: basic 2x2 pass
      push_1234();
      run_pass(0, 4, "basic");

      // 3: drawer slow to accept; draw and map address must hold
      acc_delay   = 20;
      hold_cycles = 3;
      push_1234();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!draw && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("slow_draw_seen", int'(draw), 1);
      addr0 = map_rd_addr;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!draw || map_rd_addr != addr0) bad++;
      end
      check("slow_draw_hold_bad_cycles", bad, 0);
      check("slow_addr", int'(addr0), 0);
      cyc = 0;
      while (busy && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("slow_pass_finished", int'(busy), 0);
      check("slow_sb_empty", sb.size(), 0);

      // 4: extra start mid-pass is ignored
      acc_delay   = 2;
      hold_cycles = 10;
      push_1234();
      run_pass(15, 4, "restart");

      // 5: reset during WAIT_DONE, then fresh pass from cell 0
      push(192, 0, 0);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!(drawer_active && !draw && busy) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("wd_reached", int'(drawer_active && !draw && busy), 1);
      reset = 1'b1;
      #1;
      check("abort_draw", int'(draw), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_tile_address", int'(tile_address), 0);
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      while (drawer_active && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_sb_empty", sb.size(), 0);
      push_1234();
      run_pass(0, 4, "after_abort");

      // 6: empty-tile handling, map {0,5,0,0}
      mem[0] = 5'd0; mem[1] = 5'd5; mem[2] = 5'd0; mem[3] = 5'd0;
`ifdef SKIP_EMPTY_EN
      push(960, 8, 0);
      run_pass(0, 1, "skip");
`else
      push(0, 0, 0);
      push(960, 8, 0);
      push(0, 0, 8);
      push(0, 8, 8);
      run_pass(0, 4, "noskip");
`endif
      check("final_x", int'(x_pos), 8);
      check("final_y", int'(y_pos), 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
